// File: rtl/dpo_pkg.sv
// dpo_dot_pipe shared package: mode codes and width helpers.
// Provides dpo_clog2 and dpo_fw (full-precision reduction width).
package dpo_pkg;

  localparam logic [1:0] DPO_MODE_SUM   = 2'd0;
  localparam logic [1:0] DPO_MODE_DOT   = 2'd1;
  localparam logic [1:0] DPO_MODE_SUMSQ = 2'd2;

  function automatic int dpo_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int dpo_fw(input int dw, input int nch);
    return 2 * dw + dpo_clog2(nch);
  endfunction

endpackage

// File: rtl/dpo_add_tree.sv
// dpo_add_tree: combinational unsigned N-input reduction tree.
// Ports: i_terms (N words of W bits, word j at [j*W +: W]),
//        o_sum (SW = W + clog2(N) bits, never overflows).
module dpo_add_tree
  import dpo_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int SW = W + dpo_clog2(N)
) (
  input  logic [N*W-1:0] i_terms,
  output logic [SW-1:0]  o_sum
);

  localparam int L = dpo_clog2(N);
  localparam int P = 1 << L;

  // Level 0 holds the inputs padded with zeros up to a power of two;
  // each following level halves the number of partial sums.
  logic [SW-1:0] w_lvl [L+1][P];

  always_comb begin
    for (int l = 0; l <= L; l++)
      for (int j = 0; j < P; j++)
        w_lvl[l][j] = '0;
    for (int j = 0; j < N; j++)
      w_lvl[0][j] = SW'(i_terms[j*W +: W]);
    for (int l = 0; l < L; l++)
      for (int j = 0; j < (P >> (l + 1)); j++)
        w_lvl[l+1][j] = w_lvl[l][2*j] + w_lvl[l][2*j+1];
  end

  assign o_sum = w_lvl[L][0];

endmodule

// File: rtl/dpo_dot_pipe.sv
// dpo_dot_pipe: 3-stage SUM / pairwise DOT / SUMSQ reduction of NCH
// unsigned DW-bit channels to an OW-bit result, vld/busy on both sides.
// Ports: clk, rst (async, active-low), din_vld/din_busy/din_mode/
//        din_data (channel i at [i*DW +: DW]), dout_vld/dout_busy/dout_data.
// Option: define DPO_SAT_EN to saturate (instead of wrap) when OW < FW.
module dpo_dot_pipe
  import dpo_pkg::*;
#(
  parameter int NCH = 8,
  parameter int DW  = 8,
  parameter int OW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_vld,
  output logic              din_busy,
  input  logic [1:0]        din_mode,
  input  logic [NCH*DW-1:0] din_data,
  output logic              dout_vld,
  input  logic              dout_busy,
  output logic [OW-1:0]     dout_data
);

  localparam int FW = dpo_fw(DW, NCH);
  localparam int TW = 2 * DW;

  logic                r_rst_done;
  logic                r_s1_vld;
  logic [1:0]          r_s1_mode;
  logic [NCH*DW-1:0]   r_s1_data;
  logic                r_s2_vld;
  logic [NCH*TW-1:0]   r_s2_terms;
  logic                r_dout_vld;
  logic [OW-1:0]       r_dout_data;

  logic                w_stall;
  logic                w_accept;
  logic                w_is_dot;
  logic                w_is_sq;
  logic [NCH*TW-1:0]   w_terms;
  logic [FW-1:0]       w_sum;
  logic [OW-1:0]       w_fit;

  // A held result freezes the whole pipe; no bubble squeezing.
  assign w_stall  = r_dout_vld & dout_busy;
  assign din_busy = w_stall | ~r_rst_done;
  assign w_accept = din_vld & ~din_busy;

  assign dout_vld  = r_dout_vld;
  assign dout_data = r_dout_data;

  // Reserved mode 3 falls through to SUM.
  assign w_is_dot = (r_s1_mode == DPO_MODE_DOT);
  assign w_is_sq  = (r_s1_mode == DPO_MODE_SUMSQ);

  always_comb begin
    w_terms = '0;
    unique case (1'b1)
      w_is_dot:
        for (int k = 0; k < NCH / 2; k++)
          w_terms[k*TW +: TW] =
            TW'(r_s1_data[(2*k)*DW +: DW]) *
            TW'(r_s1_data[(2*k+1)*DW +: DW]);
      w_is_sq:
        for (int k = 0; k < NCH; k++)
          w_terms[k*TW +: TW] =
            TW'(r_s1_data[k*DW +: DW]) *
            TW'(r_s1_data[k*DW +: DW]);
      default:
        for (int k = 0; k < NCH; k++)
          w_terms[k*TW +: TW] = TW'(r_s1_data[k*DW +: DW]);
    endcase
  end

  dpo_add_tree #(
    .N  (NCH),
    .W  (TW),
    .SW (FW)
  ) u_tree (
    .i_terms (r_s2_terms),
    .o_sum   (w_sum)
  );

  // Cast zero-extends when OW >= FW, otherwise keeps the low OW bits.
  always_comb begin
`ifdef DPO_SAT_EN
    if (FW > OW && (w_sum >> OW) != '0)
      w_fit = '1;
    else
      w_fit = OW'(w_sum);
`else
    w_fit = OW'(w_sum);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_done  <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_mode   <= DPO_MODE_SUM;
      r_s1_data   <= '0;
      r_s2_vld    <= 1'b0;
      r_s2_terms  <= '0;
      r_dout_vld  <= 1'b0;
      r_dout_data <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (!w_stall) begin
        r_s1_vld <= w_accept;
        if (w_accept) begin
          r_s1_mode <= din_mode;
          r_s1_data <= din_data;
        end
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld)
          r_s2_terms <= w_terms;
        r_dout_vld <= r_s2_vld;
        if (r_s2_vld)
          r_dout_data <= w_fit;
      end
    end
  end

endmodule

// File: tb/tb_dpo_dot_pipe.sv
// tb_dpo_dot_pipe: directed self-checking bench for dpo_dot_pipe
// (NCH=8, DW=8; OW=32 main instance plus an OW=16 instance).
module tb_dpo_dot_pipe;
  import dpo_pkg::*;

  localparam logic [63:0] V18  = 64'h0807060504030201;
  localparam logic [63:0] V255 = {64{1'b1}};

`ifdef DPO_SAT_EN
  localparam logic [63:0] EXP16 = 64'd65535;
`else
  localparam logic [63:0] EXP16 = 64'd63492;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_vld = 1'b0;
  logic        dout_busy = 1'b0;
  logic [1:0]  din_mode = 2'd0;
  logic [63:0] din_data = '0;
  logic        din_busy;
  logic        dout_vld;
  logic [31:0] dout_data;
  logic        din_busy16;
  logic        dout_vld16;
  logic [15:0] dout_data16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpo_dot_pipe #(.NCH(8), .DW(8), .OW(32)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .din_vld   (din_vld),
    .din_busy  (din_busy),
    .din_mode  (din_mode),
    .din_data  (din_data),
    .dout_vld  (dout_vld),
    .dout_busy (dout_busy),
    .dout_data (dout_data)
  );

  dpo_dot_pipe #(.NCH(8), .DW(8), .OW(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .din_vld   (din_vld),
    .din_busy  (din_busy16),
    .din_mode  (din_mode),
    .din_data  (din_data),
    .dout_vld  (dout_vld16),
    .dout_busy (dout_busy),
    .dout_data (dout_data16)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag,
                          input logic [1:0] mode,
                          input logic [63:0] data,
                          input logic [63:0] exp);
    din_mode = mode;
    din_data = data;
    din_vld  = 1'b1;
    tick();
    din_vld = 1'b0;
    chk({tag, "_vld_e0"}, 64'(dout_vld), 64'd0);
    tick();
    chk({tag, "_vld_e1"}, 64'(dout_vld), 64'd0);
    tick();
    chk({tag, "_vld_e2"}, 64'(dout_vld), 64'd1);
    chk({tag, "_data"}, 64'(dout_data), exp);
    tick();
    chk({tag, "_vld_e3"}, 64'(dout_vld), 64'd0);
    chk({tag, "_hold"}, 64'(dout_data), exp);
  endtask

  int          t5_dv [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int          t5_vi [11] = '{0, 1, 2, 3, 3, 3, 3, 0, 0, 0, 0};
  int          t5_ob [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  int          t5_eb [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  int          t5_ev [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  int          t5_ed [11] = '{0, 0, 0, 36, 36, 36, 36, 100, 204, 2040, 0};
  logic [1:0]  t5_md [4]  = '{DPO_MODE_SUM, DPO_MODE_DOT,
                              DPO_MODE_SUMSQ, DPO_MODE_SUM};
  logic [63:0] t5_dt [4]  = '{V18, V18, V18, V255};

  initial begin
    int seen;

    // Reset state and release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(dout_vld), 64'd0);
    chk("rst_data", 64'(dout_data), 64'd0);
    chk("rst_busy", 64'(din_busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("rel_busy_pre", 64'(din_busy), 64'd1);
    tick();
    chk("rel_busy_post", 64'(din_busy), 64'd0);

    // Single transactions
    send_one("sum18", DPO_MODE_SUM, V18, 64'd36);
    send_one("dot18", DPO_MODE_DOT, V18, 64'd100);
    send_one("rsv18", 2'd3, V18, 64'd36);
    send_one("sq255", DPO_MODE_SUMSQ, V255, 64'd520200);

    // Back-to-back modes, one result per cycle
    din_data = V18;
    din_vld  = 1'b1;
    din_mode = DPO_MODE_SUM;
    tick();
    din_mode = DPO_MODE_DOT;
    tick();
    din_mode = DPO_MODE_SUMSQ;
    tick();
    din_vld = 1'b0;
    chk("b2b_vld0", 64'(dout_vld), 64'd1);
    chk("b2b_sum", 64'(dout_data), 64'd36);
    tick();
    chk("b2b_vld1", 64'(dout_vld), 64'd1);
    chk("b2b_dot", 64'(dout_data), 64'd100);
    tick();
    chk("b2b_vld2", 64'(dout_vld), 64'd1);
    chk("b2b_sq", 64'(dout_data), 64'd204);
    tick();
    chk("b2b_idle", 64'(dout_vld), 64'd0);

    // Backpressure mid-stream
    for (int c = 0; c < 11; c++) begin
      din_vld   = (t5_dv[c] != 0);
      din_mode  = t5_md[t5_vi[c]];
      din_data  = t5_dt[t5_vi[c]];
      dout_busy = (t5_ob[c] != 0);
      #1;
      chk($sformatf("bp_busy_c%0d", c), 64'(din_busy), 64'(t5_eb[c]));
      chk($sformatf("bp_vld_c%0d", c), 64'(dout_vld), 64'(t5_ev[c]));
      if (t5_ev[c] != 0)
        chk($sformatf("bp_data_c%0d", c), 64'(dout_data), 64'(t5_ed[c]));
      @(posedge clk);
      #1;
    end
    din_vld   = 1'b0;
    dout_busy = 1'b0;

    // OW=16 wrap / saturate
    din_mode = DPO_MODE_DOT;
    din_data = V255;
    din_vld  = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    tick();
    chk("ow32_dot255", 64'(dout_data), 64'd260100);
    chk("ow16_vld", 64'(dout_vld16), 64'd1);
    chk("ow16_busy", 64'(din_busy16), 64'd0);
    chk("ow16_dot255", 64'(dout_data16), EXP16);
    tick();

    // Reset with two vectors in flight behind a valid result
    din_data = V18;
    din_vld  = 1'b1;
    din_mode = DPO_MODE_SUM;
    tick();
    din_mode = DPO_MODE_DOT;
    tick();
    din_mode = DPO_MODE_SUMSQ;
    tick();
    din_vld = 1'b0;
    chk("mid_pre_vld", 64'(dout_vld), 64'd1);
    chk("mid_pre_data", 64'(dout_data), 64'd36);
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(dout_vld), 64'd0);
    chk("mid_rst_data", 64'(dout_data), 64'd0);
    chk("mid_rst_busy", 64'(din_busy), 64'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rel_busy_pre", 64'(din_busy), 64'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dout_vld) seen++;
    end
    chk("mid_rel_busy", 64'(din_busy), 64'd0);
    chk("mid_discard", 64'(seen), 64'd0);
    chk("mid_data_zero", 64'(dout_data), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
